// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FIN
  } state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Controller-side and circuit-side signals of one sweeper; slave = sweeper, master = its environment.
interface truth_table_sweeper_if;

  logic        start;
  logic        abort;
  logic [15:0] expected_tt;
  logic        vec_in1;
  logic        vec_in2;
  logic        vec_in3;
  logic        vec_in4;
  logic        circ_out;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic        pass;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic        fail_seen;

  modport slave (
    input  start, abort, expected_tt, circ_out,
    output vec_in1, vec_in2, vec_in3, vec_in4,
    output busy, done, tt, pass, mismatch_cnt, first_fail_idx, fail_seen
  );

  modport master (
    output start, abort, expected_tt, circ_out,
    input  vec_in1, vec_in2, vec_in3, vec_in4,
    input  busy, done, tt, pass, mismatch_cnt, first_fail_idx, fail_seen
  );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
module tt_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 vectors into one 4-in/1-out circuit, captures its truth table and compares it.
// done pulses in cycle 16*(SETTLE_CYCLES+2)+1 after the start cycle; start ignored while busy.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  truth_table_sweeper_if.slave bus
);

  // Timer runs SETTLE_CYCLES-1 down to 0, one SETTLE cycle per count.
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     vec_q, vec_d;
  logic [NUM_VEC-1:0]   tt_q, tt_d;
  logic [NUM_VEC-1:0]   exp_q, exp_d;
  logic [4:0]           mm_q, mm_d;
  logic [IDX_W-1:0]     ff_q, ff_d;
  logic                 fs_q, fs_d;
  logic                 pass_q, pass_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tmr_load, tmr_dec, tmr_zero;

  tt_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    tt_d     = tt_q;
    exp_d    = exp_q;
    mm_d     = mm_q;
    ff_d     = ff_q;
    fs_d     = fs_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      vec_d   = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            exp_d   = bus.expected_tt;
            tt_d    = '0;
            mm_d    = '0;
            ff_d    = '0;
            fs_d    = 1'b0;
            pass_d  = 1'b0;
            idx_d   = '0;
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          vec_d    = idx_q;
          tmr_load = 1'b1;
          state_d  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          tmr_dec = 1'b1;
          if (tmr_zero) begin
            state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          tt_d[idx_q] = bus.circ_out;
          if (bus.circ_out != exp_q[idx_q]) begin
            mm_d = mm_q + 5'd1;
            if (!fs_q) begin
              ff_d = idx_q;
              fs_d = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_VEC - 1)) begin
            state_d = FIN;
            done_d  = 1'b1;
            pass_d  = (mm_d == 5'd0);
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DRIVE;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vec_in1        = vec_q[3];
  assign bus.vec_in2        = vec_q[2];
  assign bus.vec_in3        = vec_q[1];
  assign bus.vec_in4        = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.tt             = tt_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_cnt   = mm_q;
  assign bus.first_fail_idx = ff_q;
  assign bus.fail_seen      = fs_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (settle 4, 2, 0) each driving a table-defined circuit, optionally delayed 3 cycles.
module tb_truth_table_sweeper;
  import tt_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          sc_a [3] = '{4, 2, 0};
  logic        start_a [3];
  logic        abort_a [3];
  logic [15:0] exp_a [3];
  logic [15:0] fn_a [3];
  logic        dly_a [3];
  logic [3:0]  vec_a [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic [15:0] tt_a [3];
  logic        pass_a [3];
  logic [4:0]  mm_a [3];
  logic [3:0]  ff_a [3];
  logic        fs_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SC = (g == 0) ? 4 : (g == 1) ? 2 : 0;
    truth_table_sweeper_if b ();
    logic [2:0] dl = 3'b000;
    logic       f_now;

    assign b.start       = start_a[g];
    assign b.abort       = abort_a[g];
    assign b.expected_tt = exp_a[g];
    assign vec_a[g]      = {b.vec_in1, b.vec_in2, b.vec_in3, b.vec_in4};
    assign busy_a[g]     = b.busy;
    assign done_a[g]     = b.done;
    assign tt_a[g]       = b.tt;
    assign pass_a[g]     = b.pass;
    assign mm_a[g]       = b.mismatch_cnt;
    assign ff_a[g]       = b.first_fail_idx;
    assign fs_a[g]       = b.fail_seen;

    assign f_now = fn_a[g][vec_a[g]];
    always @(posedge clk) dl <= {dl[1:0], f_now};
    assign b.circ_out = dly_a[g] ? dl[2] : f_now;

    truth_table_sweeper #(.SETTLE_CYCLES(SC), .CNT_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int g, input string tag);
    chk({tag, "_outputs"},
        {busy_a[g], done_a[g], pass_a[g], fs_a[g], vec_a[g], ff_a[g], mm_a[g], tt_a[g]}, 32'h0);
  endtask

  // Vector k is visible from cycle 2+k*(S+2) for S+2 cycles; watch until done or stop_at.
  task automatic run(input int g, input logic [15:0] exp_tt, input int stop_at,
                     input int poke_at, output int n, output bit got_done);
    int s;
    int bad_vec;
    int bad_busy;
    s = sc_a[g];
    @(negedge clk);
    start_a[g] = 1'b1;
    exp_a[g]   = exp_tt;
    @(negedge clk);
    start_a[g] = 1'b0;
    exp_a[g]   = ~exp_tt;
    n = 1; got_done = 1'b0; bad_vec = 0; bad_busy = 0;
    while (1) begin
      if (busy_a[g] !== 1'b1) bad_busy++;
      if (n >= 2 && vec_a[g] !== 4'((n - 2) / (s + 2))) bad_vec++;
      if (done_a[g] === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (n == stop_at || n > 400) break;
      start_a[g] = (n == poke_at);
      @(negedge clk);
      n++;
    end
    start_a[g] = 1'b0;
    chk("busy_held", bad_busy, 0);
    chk("vec_sequence", bad_vec, 0);
  endtask

  task automatic sweep_check(input int g, input logic [15:0] tt_exp,
                             input logic [15:0] exp_tt, input string tag);
    int n;
    bit gd;
    logic [15:0] diff;
    logic [3:0]  ff;
    diff = tt_exp ^ exp_tt;
    ff = 4'd0;
    for (int i = 15; i >= 0; i--) if (diff[i]) ff = 4'(i);
    run(g, exp_tt, -1, -1, n, gd);
    chk({tag, "_done"}, gd, 1);
    chk({tag, "_latency"}, n, 16 * (sc_a[g] + 2) + 1);
    chk({tag, "_tt"}, tt_a[g], tt_exp);
    chk({tag, "_mismatch_cnt"}, mm_a[g], popcount16(diff));
    chk({tag, "_first_fail_idx"}, ff_a[g], ff);
    chk({tag, "_fail_seen"}, fs_a[g], diff != 16'h0);
    chk({tag, "_pass"}, pass_a[g], diff == 16'h0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy_a[g], done_a[g]}, 2'b00);
    repeat (3) @(negedge clk);
    chk({tag, "_pass_held"}, pass_a[g], diff == 16'h0);
  endtask

  task automatic watch_no_done(input int g, input int cycles, input string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done_a[g] !== 1'b0 || busy_a[g] !== 1'b0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit gd;
    logic [15:0] f;
    logic [15:0] m;
    int g;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; abort_a[i] = 1'b0; exp_a[i] = 16'h0;
      fn_a[i] = 16'h0; dly_a[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset(i, "reset");
    rst = 1'b0;

    // Directed: matching circuit, then AND circuit.
    fn_a[0] = 16'h0018;
    sweep_check(0, 16'h0018, 16'h0018, "t1_match");
    fn_a[0] = 16'h8000;
    sweep_check(0, 16'h8000, 16'h0018, "t2_and");

    // A 3-cycle-late circuit: with settle 2 each sample sees the previous vector's answer.
    fn_a[1] = 16'h0018; dly_a[1] = 1'b1;
    sweep_check(1, {fn_a[1][14:0], fn_a[1][0]}, 16'h0018, "t3_settle2");
    fn_a[0] = 16'h0018; dly_a[0] = 1'b1;
    sweep_check(0, 16'h0018, 16'h0018, "t3_settle4");
    dly_a[0] = 1'b0; dly_a[1] = 1'b0;

    // Zero settle build.
    f = 16'($urandom);
    fn_a[2] = f;
    sweep_check(2, f, f ^ 16'h0401, "t4_settle0");

    // Abort in SAMPLE of idx 7 (cycle 7*6+6).
    f = 16'($urandom);
    fn_a[0] = f;
    run(0, f, 48, -1, n, gd);
    chk("t5_no_done_before", gd, 0);
    chk("t5_partial_tt", tt_a[0], f & 16'h007F);
    abort_a[0] = 1'b1;
    @(negedge clk);
    abort_a[0] = 1'b0;
    chk("t5_after_abort", {busy_a[0], done_a[0], pass_a[0], vec_a[0]}, 7'h0);
    watch_no_done(0, 120, "t5_no_done_after");
    sweep_check(0, f, f, "t5_resweep");

    // start and abort together in IDLE.
    @(negedge clk);
    start_a[0] = 1'b1; abort_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0; abort_a[0] = 1'b0;
    chk("start_abort_idle_pass", pass_a[0], 0);
    watch_no_done(0, 20, "start_abort_idle");

    // Mid-sweep start ignored, then rst while vector 9 is held.
    f = 16'($urandom) | 16'h0001;
    fn_a[0] = f;
    run(0, f, 58, 10, n, gd);
    chk("t6_no_done_before", gd, 0);
    chk("t6_partial_tt", tt_a[0], f & 16'h01FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset(0, "t6_after_rst");
    watch_no_done(0, 120, "t6_no_done_after");

    // Random tables and random expected codes on random instances.
    for (int r = 0; r < 6; r++) begin
      g = int'($urandom_range(0, 2));
      f = 16'($urandom);
      m = (r == 0) ? 16'h0 : 16'($urandom & $urandom);
      fn_a[g] = f;
      sweep_check(g, f, f ^ m, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
